// File: rtl/stopwatch_timer_core_if.sv
// Control and display signals between the stopwatch/timer core and its user.
// The master drives the pulses and preset digits; the core (slave) drives the BCD digits and status.
interface stopwatch_timer_core_if;
  logic       mode;
  logic       startStop;
  logic       clear;
  logic       load;
  logic [3:0] loadMinTens;
  logic [3:0] loadMinOnes;
  logic [3:0] loadSecTens;
  logic [3:0] loadSecOnes;
  logic [3:0] csOnes;
  logic [3:0] csTens;
  logic [3:0] secOnes;
  logic [3:0] secTens;
  logic [3:0] minOnes;
  logic [3:0] minTens;
  logic       running;
  logic       done;

  modport master (
    output mode, startStop, clear, load,
    output loadMinTens, loadMinOnes, loadSecTens, loadSecOnes,
    input  csOnes, csTens, secOnes, secTens, minOnes, minTens, running, done
  );

  modport slave (
    input  mode, startStop, clear, load,
    input  loadMinTens, loadMinOnes, loadSecTens, loadSecOnes,
    output csOnes, csTens, secOnes, secTens, minOnes, minTens, running, done
  );
endinterface

// File: rtl/stopwatch_timer_core.sv
// MM:SS.cc stopwatch/timer core: prescaler to a 1/100 s tick, six BCD digits counting up or down.
// Digits are packed {minTens, minOnes, secTens, secOnes, csTens, csOnes}; every output is registered.
module stopwatch_timer_core #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  stopwatch_timer_core_if.slave  sw
);

  localparam int              TP      = CLK_HZ / TICK_HZ;
  localparam int              PW      = (TP > 2) ? $clog2(TP) : 1;
  localparam logic [PW-1:0]   TP_LAST = PW'(TP - 1);
  localparam logic [23:0]     MAX_UP  = 24'h995999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   digits_q, digits_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          tick_s;
  logic [23:0]   load_val_s;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Ripple increment; secTens (digit 3) wraps after 5, all others after 9.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        c;
    logic [3:0]  lim;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (c) begin
        if (r[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        b;
    logic [3:0]  lim;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = lim;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        b = 1'b0;
      end
    end
    return r;
  endfunction

  assign load_val_s = {clamp(sw.loadMinTens, 4'd9), clamp(sw.loadMinOnes, 4'd9),
                       clamp(sw.loadSecTens, 4'd5), clamp(sw.loadSecOnes, 4'd9), 8'h00};
  assign tick_s     = (state_q == RUN) && (presc_q == TP_LAST);

  // Next-state: clear beats load beats startStop; a terminal tick beats a same-cycle pause.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    if (sw.clear) begin
      state_d  = IDLE;
      presc_d  = '0;
      digits_d = 24'h000000;
    end else begin
      case (state_q)
        IDLE: begin
          if (sw.load) begin
            digits_d = load_val_s;
            presc_d  = '0;
          end else if (sw.startStop && !(sw.mode && (digits_q == 24'h000000))) begin
            state_d = RUN;
            mode_d  = sw.mode;
            presc_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (tick_s) begin
            presc_d = '0;
            if (!mode_q) begin
              if (digits_q == MAX_UP) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
              end else begin
                digits_d = bcd_inc(digits_q);
                state_d  = sw.startStop ? PAUSE : RUN;
              end
            end else begin
              if (digits_q == 24'h000000) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
              end else begin
                digits_d = bcd_dec(digits_q);
                if (digits_d == 24'h000000) begin
                  state_d = EXPIRED;
                  done_d  = 1'b1;
                end else begin
                  state_d = sw.startStop ? PAUSE : RUN;
                end
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
            state_d = sw.startStop ? PAUSE : RUN;
          end
        end
        PAUSE: begin
          if (sw.load) begin
            digits_d = load_val_s;
            presc_d  = '0;
          end else if (sw.startStop) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        EXPIRED: begin
          if (sw.load) begin
            digits_d = load_val_s;
            presc_d  = '0;
            state_d  = IDLE;
          end else begin
            state_d = EXPIRED;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  // State, prescaler, digits and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      presc_q   <= '0;
      digits_q  <= 24'h000000;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sw.csOnes  = digits_q[3:0];
  assign sw.csTens  = digits_q[7:4];
  assign sw.secOnes = digits_q[11:8];
  assign sw.secTens = digits_q[15:12];
  assign sw.minOnes = digits_q[19:16];
  assign sw.minTens = digits_q[23:20];
  assign sw.running = running_q;
  assign sw.done    = done_q;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench for stopwatch_timer_core with TP = 10 cycles; inputs change and outputs are sampled on falling edges.
module tb_stopwatch_timer_core;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  stopwatch_timer_core_if sw();

  stopwatch_timer_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] disp();
    return {sw.minTens, sw.minOnes, sw.secTens, sw.secOnes, sw.csTens, sw.csOnes};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    sw.startStop = 1'b1;
    @(negedge clk);
    sw.startStop = 1'b0;
  endtask

  task automatic pulse_clear();
    sw.clear = 1'b1;
    @(negedge clk);
    sw.clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] mt, input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so);
    sw.loadMinTens = mt;
    sw.loadMinOnes = mo;
    sw.loadSecTens = st;
    sw.loadSecOnes = so;
    sw.load        = 1'b1;
    @(negedge clk);
    sw.load        = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    sw.mode = 1'b0; sw.startStop = 1'b0; sw.clear = 1'b0; sw.load = 1'b0;
    sw.loadMinTens = 4'd0; sw.loadMinOnes = 4'd0; sw.loadSecTens = 4'd0; sw.loadSecOnes = 4'd0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    chk("reset_digits", disp(), 24'h000000);
    chk("reset_running", {23'd0, sw.running}, 24'd0);
    chk("reset_done", {23'd0, sw.done}, 24'd0);

    // 1: count up from zero
    pulse_start();
    chk("t1_running", {23'd0, sw.running}, 24'd1);
    cyc(9);
    chk("t1_before_tick", disp(), 24'h000000);
    cyc(1);
    chk("t1_first_tick", disp(), 24'h000001);
    cyc(990);
    chk("t1_100_ticks", disp(), 24'h000100);
    pulse_clear();
    chk("t1_clear", disp(), 24'h000000);
    chk("t1_clear_run", {23'd0, sw.running}, 24'd0);

    // 2: carry into minutes, then saturation at 99:59.99
    do_load(4'd0, 4'd0, 4'd5, 4'd9);
    chk("t2_load", disp(), 24'h005900);
    pulse_start();
    cyc(1000);
    chk("t2_min_carry", disp(), 24'h010000);
    pulse_clear();
    do_load(4'd9, 4'd9, 4'd5, 4'd9);
    pulse_start();
    cyc(990);
    chk("t2_max", disp(), 24'h995999);
    chk("t2_no_done", {23'd0, sw.done}, 24'd0);
    cyc(10);
    chk("t2_hold", disp(), 24'h995999);
    chk("t2_done", {23'd0, sw.done}, 24'd1);
    chk("t2_stopped", {23'd0, sw.running}, 24'd0);
    cyc(1);
    chk("t2_done_pulse", {23'd0, sw.done}, 24'd0);
    chk("t2_hold2", disp(), 24'h995999);

    // 3: count down, expiry, ignored start
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    chk("t3_load_expired", disp(), 24'h010000);
    sw.mode = 1'b1;
    pulse_start();
    chk("t3_running", {23'd0, sw.running}, 24'd1);
    cyc(10);
    chk("t3_borrow", disp(), 24'h005999);
    pulse_clear();
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    pulse_start();
    cyc(999);
    chk("t3_last", disp(), 24'h000001);
    chk("t3_no_done", {23'd0, sw.done}, 24'd0);
    cyc(1);
    chk("t3_zero", disp(), 24'h000000);
    chk("t3_done", {23'd0, sw.done}, 24'd1);
    chk("t3_stopped", {23'd0, sw.running}, 24'd0);
    pulse_start();
    chk("t3_done_low", {23'd0, sw.done}, 24'd0);
    chk("t3_start_ignored", {23'd0, sw.running}, 24'd0);
    pulse_clear();
    pulse_start();
    chk("t3_zero_down_start", {23'd0, sw.running}, 24'd0);

    // 4: pause holds the prescaler, resume continues from it
    sw.mode = 1'b0;
    pulse_start();
    cyc(14);
    pulse_start();
    chk("t4_paused", {23'd0, sw.running}, 24'd0);
    chk("t4_value", disp(), 24'h000001);
    cyc(50);
    chk("t4_frozen", disp(), 24'h000001);
    pulse_start();
    chk("t4_resumed", {23'd0, sw.running}, 24'd1);
    cyc(4);
    chk("t4_before_tick", disp(), 24'h000001);
    cyc(1);
    chk("t4_tick", disp(), 24'h000002);

    // 5: clear beats start; load clamping; load ignored in RUN
    sw.clear = 1'b1;
    sw.startStop = 1'b1;
    @(negedge clk);
    sw.clear = 1'b0;
    sw.startStop = 1'b0;
    chk("t5_clear_wins", disp(), 24'h000000);
    chk("t5_clear_run", {23'd0, sw.running}, 24'd0);
    do_load(4'hA, 4'hC, 4'd7, 4'd4);
    chk("t5_clamp", disp(), 24'h995400);
    pulse_start();
    cyc(3);
    sw.startStop = 1'b1;
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    sw.startStop = 1'b0;
    chk("t5_load_in_run", disp(), 24'h995400);
    chk("t5_pause_acts", {23'd0, sw.running}, 24'd0);
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    chk("t5_load_pause", disp(), 24'h123400);

    // 6: asynchronous reset mid-run
    pulse_start();
    cyc(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_digits", disp(), 24'h000000);
    chk("t6_async_running", {23'd0, sw.running}, 24'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    pulse_start();
    chk("t6_restart", {23'd0, sw.running}, 24'd1);
    cyc(10);
    chk("t6_first_tick", disp(), 24'h000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
